// File: rtl/gpr_file_param_if.sv
// Bus bundle for gpr_file_param: clear/scrub status, one write port, two read ports.
// The master modport is the datapath side; the slave modport is the register file.
interface gpr_file_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              clear_req;
  logic              init_done;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic [ADDR_W-1:0] reg_read_addr_1;
  logic [DATA_W-1:0] reg_read_data_1;
  logic [ADDR_W-1:0] reg_read_addr_2;
  logic [DATA_W-1:0] reg_read_data_2;

  modport master (
    output clear_req, reg_write_en, reg_write_dest, reg_write_data,
    output reg_read_addr_1, reg_read_addr_2,
    input  init_done, reg_read_data_1, reg_read_data_2
  );

  modport slave (
    input  clear_req, reg_write_en, reg_write_dest, reg_write_data,
    input  reg_read_addr_1, reg_read_addr_2,
    output init_done, reg_read_data_1, reg_read_data_2
  );
endinterface

// File: rtl/gpr_file_param.sv
// Parametrised 2-read/1-write register file with a sequential zeroing scrub after reset/clear.
// Optional macro GPRF_BYPASS_EN forwards same-cycle write data to matching read ports.
module gpr_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  gpr_file_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_scrub_cnt;
  logic              r_init_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_user_we;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  // A user write only lands in READY, not on a clear edge, and never into a hardwired zero entry.
  always_comb begin
    w_user_we  = (r_state == ST_READY) && bus.reg_write_en && !bus.clear_req &&
                 !((ZERO_REG != 0) && (bus.reg_write_dest == '0));
    w_mem_we   = 1'b0;
    w_mem_addr = bus.reg_write_dest;
    w_mem_data = bus.reg_write_data;
    if (r_state == ST_INIT) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_scrub_cnt;
      w_mem_data = '0;
    end else if (w_user_we) begin
      w_mem_we   = 1'b1;
    end
  end

  // NOTE: control state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_scrub_cnt <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (bus.clear_req) begin
            r_scrub_cnt <= '0;
          end else if (r_scrub_cnt == {ADDR_W{1'b1}}) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
            r_scrub_cnt <= '0;
          end else begin
            r_scrub_cnt <= r_scrub_cnt + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (bus.clear_req) begin
            r_state     <= ST_INIT;
            r_scrub_cnt <= '0;
            r_init_done <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_INIT;
          r_scrub_cnt <= '0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; the scrub engine zeroes it and reads are gated until it finishes.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (r_state != ST_READY) return '0;
    if ((ZERO_REG != 0) && (addr == '0)) return '0;
`ifdef GPRF_BYPASS_EN
    if (w_user_we && (bus.reg_write_dest == addr)) return bus.reg_write_data;
`endif
    return r_mem[addr];
  endfunction

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    bus.reg_read_data_1 = read_port(bus.reg_read_addr_1);
    bus.reg_read_data_2 = read_port(bus.reg_read_addr_2);
  end

  assign bus.init_done = r_init_done;
endmodule

// File: tb/tb_gpr_file_param.sv
// Self-checking bench for gpr_file_param: a default 16x8 instance and a 32x16 ZERO_REG instance,
// checked against a behavioural model plus a directed vector table and hand sequences.
module tb_gpr_file_param;
`ifdef GPRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  gpr_file_param_if #(.DATA_W(16), .ADDR_W(3)) ifa ();
  gpr_file_param_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  gpr_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  gpr_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: contents, a ready flag and the number of scrub edges still owed.
  logic [15:0] ma [8];
  logic [31:0] mb [16];
  bit          rdy_a, rdy_b;
  int          left_a, left_b;

  task automatic model_reset();
    rdy_a = 0; left_a = 8;
    rdy_b = 0; left_b = 16;
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ifa.clear_req) begin
        rdy_a = 0; left_a = 8;
        foreach (ma[i]) ma[i] = '0;
      end else if (!rdy_a) begin
        left_a--;
        if (left_a == 0) rdy_a = 1;
      end else if (ifa.reg_write_en) begin
        ma[ifa.reg_write_dest] = ifa.reg_write_data;
      end
      if (ifb.clear_req) begin
        rdy_b = 0; left_b = 16;
        foreach (mb[i]) mb[i] = '0;
      end else if (!rdy_b) begin
        left_b--;
        if (left_b == 0) rdy_b = 1;
      end else if (ifb.reg_write_en && ifb.reg_write_dest != 4'd0) begin
        mb[ifb.reg_write_dest] = ifb.reg_write_data;
      end
    end
  endtask

  function automatic logic [31:0] exp_a(input logic [2:0] addr);
    if (!rdy_a) return 32'd0;
    if (BYP && ifa.reg_write_en && !ifa.clear_req && ifa.reg_write_dest == addr)
      return {16'd0, ifa.reg_write_data};
    return {16'd0, ma[addr]};
  endfunction

  function automatic logic [31:0] exp_b(input logic [3:0] addr);
    if (!rdy_b || addr == 4'd0) return 32'd0;
    if (BYP && ifb.reg_write_en && !ifb.clear_req && ifb.reg_write_dest == addr)
      return ifb.reg_write_data;
    return mb[addr];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a_done"}, {31'd0, ifa.init_done}, {31'd0, rdy_a});
    check({tag, ".a_rd1"},  {16'd0, ifa.reg_read_data_1}, exp_a(ifa.reg_read_addr_1));
    check({tag, ".a_rd2"},  {16'd0, ifa.reg_read_data_2}, exp_a(ifa.reg_read_addr_2));
    check({tag, ".b_done"}, {31'd0, ifb.init_done}, {31'd0, rdy_b});
    check({tag, ".b_rd1"},  ifb.reg_read_data_1, exp_b(ifb.reg_read_addr_1));
    check({tag, ".b_rd2"},  ifb.reg_read_data_2, exp_b(ifb.reg_read_addr_2));
  endtask

  task automatic drive_a(input logic we, input logic [2:0] d, input logic [15:0] dat,
                         input logic [2:0] r1, input logic [2:0] r2, input logic clr);
    ifa.reg_write_en = we; ifa.reg_write_dest = d; ifa.reg_write_data = dat;
    ifa.reg_read_addr_1 = r1; ifa.reg_read_addr_2 = r2; ifa.clear_req = clr;
  endtask

  task automatic drive_b(input logic we, input logic [3:0] d, input logic [31:0] dat,
                         input logic [3:0] r1, input logic [3:0] r2, input logic clr);
    ifb.reg_write_en = we; ifb.reg_write_dest = d; ifb.reg_write_data = dat;
    ifb.reg_read_addr_1 = r1; ifb.reg_read_addr_2 = r2; ifb.clear_req = clr;
  endtask

  // Model follows the inputs held across the edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic count_to_ready(output int na, output int nb);
    na = 0; nb = 0;
    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (na == 0 && ifa.init_done) na = i;
      if (nb == 0 && ifb.init_done) nb = i;
      if (na != 0 && nb != 0) break;
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  dest;
    logic [15:0] data;
    logic [2:0]  a1, a2;
    logic [15:0] e1_nb, e2_nb, e1_b, e2_b;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int na, nb;

    tbl[0] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd4, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    tbl[2] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
    tbl[3] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd4, 16'h1234, 16'h0000, 16'h1234, 16'h0000};
    tbl[4] = '{1'b1, 3'd7, 16'h0001, 3'd7, 3'd5, 16'h0000, 16'hBEEF, 16'h0001, 16'hBEEF};
    tbl[5] = '{1'b1, 3'd0, 16'hAAAA, 3'd0, 3'd7, 16'h0000, 16'h0001, 16'hAAAA, 16'h0001};
    tbl[6] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'hAAAA, 16'h1234, 16'hAAAA, 16'h1234};

    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset.a_done", {31'd0, ifa.init_done}, 32'd0);
    check("reset.a_rd1", {16'd0, ifa.reg_read_data_1}, 32'd0);
    check("reset.a_rd2", {16'd0, ifa.reg_read_data_2}, 32'd0);
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Scrub after reset release, with writes attempted while each instance is still in INIT.
    for (int i = 0; i < 17; i++) begin
      drive_a(!rdy_a && $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
              3'($urandom), 3'($urandom), 0);
      drive_b(!rdy_b && $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
              4'($urandom), 4'($urandom), 0);
      #2;
      check("scrub.a_latency", {31'd0, ifa.init_done}, {31'd0, i >= 8});
      check("scrub.b_latency", {31'd0, ifb.init_done}, {31'd0, i >= 16});
      check_all("scrub");
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive_a(0, 0, 0, 3'(i), 3'(i + 1), 0);
      drive_b(0, 0, 0, 4'(i), 4'(i + 1), 0);
      #2;
      check("init_clean.a", {16'd0, ifa.reg_read_data_1}, 32'd0);
      check("init_clean.b", ifb.reg_read_data_1, 32'd0);
      check_all("init_clean");
    end

    // Directed table on the default instance, starting from an all-zero file.
    for (int i = 0; i < 7; i++) begin
      drive_a(tbl[i].we, tbl[i].dest, tbl[i].data, tbl[i].a1, tbl[i].a2, 0);
      drive_b(0, 0, 0, 4'($urandom), 4'($urandom), 0);
      #2;
      check($sformatf("tbl%0d.rd1", i), {16'd0, ifa.reg_read_data_1},
            {16'd0, BYP ? tbl[i].e1_b : tbl[i].e1_nb});
      check($sformatf("tbl%0d.rd2", i), {16'd0, ifa.reg_read_data_2},
            {16'd0, BYP ? tbl[i].e2_b : tbl[i].e2_nb});
      check_all("tbl");
      tick();
    end

    // ZERO_REG instance: r0 is hardwired, r1 and r15 behave normally.
    drive_b(1, 4'd0, 32'h0000_AAAA, 4'd0, 4'd0, 0);
    #2; check("zr.r0_same", ifb.reg_read_data_1, 32'd0); check_all("zr");
    tick();
    drive_b(1, 4'd1, 32'h0000_5555, 4'd0, 4'd1, 0);
    #2;
    check("zr.r0_after", ifb.reg_read_data_1, 32'd0);
    check("zr.r1_same", ifb.reg_read_data_2, BYP ? 32'h0000_5555 : 32'd0);
    check_all("zr");
    tick();
    drive_b(1, 4'd15, 32'hDEAD_BEEF, 4'd1, 4'd15, 0);
    #2; check("zr.r1_after", ifb.reg_read_data_1, 32'h0000_5555); check_all("zr");
    tick();
    drive_b(0, 0, 0, 4'd15, 4'd0, 0);
    #2; check("wide.r15", ifb.reg_read_data_1, 32'hDEAD_BEEF); check_all("wide");

    // Fill, clear with a write in the same cycle, re-clear at scrub cycle 4.
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 3'(i), 16'hFFFF, 3'(i), 3'(i), 0);
      tick();
    end
    drive_a(0, 0, 0, 3'd2, 3'd6, 0);
    #2; check("fill.r2", {16'd0, ifa.reg_read_data_1}, 32'h0000_FFFF); check_all("fill");
    drive_a(1, 3'd2, 16'h1234, 3'd2, 3'd6, 1);
    #2; check_all("clr");
    tick();
    drive_a(0, 0, 0, 3'd2, 3'd6, 0);
    #2;
    check("clr.done_drop", {31'd0, ifa.init_done}, 32'd0);
    check("clr.rd_zero", {16'd0, ifa.reg_read_data_1}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    drive_a(0, 0, 0, 0, 0, 1);
    tick();
    count_to_ready(na, nb);
    check("clr.restart_latency", na, 32'd8);
    for (int i = 0; i < 8; i++) begin
      drive_a(0, 0, 0, 3'(i), 3'(7 - i), 0);
      #2;
      check("clr.zero", {16'd0, ifa.reg_read_data_1}, 32'd0);
      check_all("clr_sweep");
    end

    // Asynchronous reset in the middle of a write.
    drive_a(1, 3'd6, 16'h7777, 3'd6, 3'd5, 0);
    drive_b(1, 4'd6, 32'h7777_7777, 4'd15, 4'd1, 0);
    #2; check_all("pre_rst");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.a_rd2", {16'd0, ifa.reg_read_data_2}, 32'd0);
    check("arst.b_rd1", ifb.reg_read_data_1, 32'd0);
    check("arst.a_done", {31'd0, ifa.init_done}, 32'd0);
    check_all("arst");
    tick();
    rst_n = 1'b1;
    count_to_ready(na, nb);
    check("arst.a_latency", na, 32'd8);
    check("arst.b_latency", nb, 32'd16);
    drive_a(0, 0, 0, 3'd6, 3'd5, 0);
    drive_b(0, 0, 0, 4'd15, 4'd6, 0);
    #2;
    check("arst.write_lost", {16'd0, ifa.reg_read_data_1}, 32'd0);
    check_all("arst_after");

    // Asynchronous reset in the middle of a scrub.
    drive_a(0, 0, 0, 0, 0, 1);
    tick();
    drive_a(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("srst.a_done", {31'd0, ifa.init_done}, 32'd0);
    check("srst.b_done", {31'd0, ifb.init_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    count_to_ready(na, nb);
    check("srst.a_latency", na, 32'd8);
    check("srst.b_latency", nb, 32'd16);

    // Randomised traffic with occasional clears, compared against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] da;
      logic [3:0] db;
      da = 3'($urandom);
      db = 4'($urandom);
      drive_a($urandom_range(0, 1) == 1, da, 16'($urandom),
              ($urandom_range(0, 2) == 0) ? da : 3'($urandom), 3'($urandom),
              $urandom_range(0, 40) == 0);
      drive_b($urandom_range(0, 1) == 1, db, $urandom,
              ($urandom_range(0, 2) == 0) ? db : 4'($urandom), 4'($urandom),
              $urandom_range(0, 60) == 0);
      #2;
      check_all("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gpr_file_param.md
# gpr_file_param

Parametrised general-purpose register file for the RISC core datapath, replacing the fixed 8×16 file. It has configurable data width and depth, two combinational read ports and one synchronous write port. A sequential scrub engine zeroes every entry after reset or on a software clear request, and reports completion on `init_done`. An optional compile-time bypass forwards same-cycle write data to the read ports.

## Interface
- `DATA_W`, 16, register width in bits (≥1)
- `ADDR_W`, 3, address width; depth `DEPTH = 2**ADDR_W` (1..8)
- `ZERO_REG`, 0, when 1 entry 0 always reads 0 and ignores writes

- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `clear_req`  in  1  single-cycle request to re-zero the whole file
- `init_done`  out  1  high when scrub is complete and the file is usable
- `reg_write_en`  in  1  write enable
- `reg_write_dest`  in  ADDR_W  write address
- `reg_write_data`  in  DATA_W  write data
- `reg_read_addr_1`  in  ADDR_W  read address, port 1
- `reg_read_data_1`  out  DATA_W  read data, port 1
- `reg_read_addr_2`  in  ADDR_W  read address, port 2
- `reg_read_data_2`  out  DATA_W  read data, port 2

## Operation
- FSM states: INIT and READY.
- `rst_n` low forces INIT with scrub counter 0 and `init_done` 0. Array contents are not reset directly.
- INIT:
  - Each rising edge writes 0 to entry `scrub_cnt`, then increments the counter.
  - The edge that writes entry DEPTH-1 moves to READY and sets `init_done` to 1.
  - `reg_write_en` is ignored.
  - Both read ports output 0.
- READY:
  - When `reg_write_en` is 1, `reg_write_data` is written to `reg_write_dest` on the edge.
  - Reads are combinational from the array.
  - `clear_req` moves to INIT with counter 0 and clears `init_done` on the same edge. A write in that same cycle is dropped.
- `clear_req` during INIT restarts the counter at 0, so a full DEPTH-cycle scrub is always guaranteed.
- `ZERO_REG`=1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 in every state.
  - Scrub still visits entry 0 (harmless).
- Both ports may read the same address at the same time; both return the same data.
- Address arithmetic is unsigned ADDR_W. The counter never wraps because INIT exits at DEPTH-1.
- Read data width equals DATA_W exactly. No sign or zero extension is performed.

## Timing
- Reset values: `init_done`=0, `reg_read_data_1`=0, `reg_read_data_2`=0.
- Scrub latency: `init_done` rises on the DEPTH-th rising edge after `rst_n` deasserts, or after the edge sampling `clear_req`.
  - Default DEPTH=8: 8 cycles.
- Write latency: data written at edge N is visible on the read ports after edge N. Same-cycle behaviour depends on the bypass configuration.
- Read latency: combinational from address, zero cycles.
- `rst_n` asserted mid-scrub or mid-write aborts immediately and asynchronously. The scrub restarts from entry 0 after deassertion.
- `rst_n` deassertion is synchronous to `clk` in the system. The block has no internal synchroniser.

## Configuration
- Macro `GPRF_BYPASS_EN`:
  - Defined: in READY, if `reg_write_en`=1 and `reg_write_dest` equals a port's read address, that port outputs `reg_write_data` combinationally in the same cycle.
    - Forwarding is suppressed when `clear_req`=1.
    - Forwarding is suppressed when ZERO_REG=1 and the address is 0.
  - Undefined: read ports show the old value until the write edge, with no forwarding logic.

## Test plan
- Reset release with DEPTH=8 -> `init_done` 0 for 7 edges and 1 after the 8th edge. Reads return 0 throughout. Any write issued during INIT is absent afterwards.
- READY: write 0xBEEF to r5, then read r5 on both ports -> 0xBEEF on both after the edge. r4 still reads 0.
- Same-cycle write 0x1234 to r3 while reading r3 -> 0x1234 in that cycle with `GPRF_BYPASS_EN` defined. Old value (0) in that cycle without it. 0x1234 on the next cycle in both builds.
- `clear_req` pulse after filling all entries with 0xFFFF -> `init_done` drops next edge and returns 8 cycles later. All entries then read 0. A `clear_req` at scrub cycle 4 extends completion to 8 cycles after the second pulse.
- ZERO_REG=1: write 0xAAAA to r0 -> r0 reads 0 (no forwarding). Write to r1 works normally.
- `rst_n` asserted for 1 cycle mid-scrub and mid-write -> outputs 0 immediately. Scrub restarts and completes 8 cycles after deassertion.
- DATA_W=32, ADDR_W=4 build: write 0xDEADBEEF to r15 -> reads back 0xDEADBEEF. Scrub takes 16 cycles.
